// File: rtl/ysyx_exu_rs.sv
// Reservation station for one functional unit: dispatches into the lowest free slot,
// wakes operands from parallel CDBs, and issues the oldest ready entry via an age matrix.
module ysyx_exu_rs #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RS_SIZE  = 4,
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned OP_W     = 5,
  localparam int unsigned TAG_W   = $clog2(ROB_SIZE) + 1,
  localparam int unsigned IDX_W   = $clog2(RS_SIZE),
  localparam int unsigned OCC_W   = $clog2(RS_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_pipeline,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [XLEN-1:0]          disp_vj,
  input  logic [XLEN-1:0]          disp_vk,
  input  logic [TAG_W-1:0]         disp_qj,
  input  logic [TAG_W-1:0]         disp_qk,
  input  logic [TAG_W-1:0]         disp_dest,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [XLEN-1:0]          iss_vj,
  output logic [XLEN-1:0]          iss_vk,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_pc,
  output logic [TAG_W-1:0]         iss_dest,
  output logic [OCC_W-1:0]         occupancy
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } entry_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  // older_q[i][j] set means entry j was allocated before entry i.
  logic [RS_SIZE-1:0] older_q [RS_SIZE];
  logic [RS_SIZE-1:0] older_d [RS_SIZE];

  logic [RS_SIZE-1:0] ready, sel_oh;
  logic [IDX_W-1:0]   sel_idx, alloc_idx;
  logic               iss_fire, disp_fire;
  entry_t             disp_ent;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      sel_oh[i] = ready[i] && ((older_q[i] & ready) == '0);
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
    occupancy = '0;
    for (int i = 0; i < RS_SIZE; i++) occupancy = occupancy + OCC_W'(busy_q[i]);
  end

  assign disp_ready = !(&busy_q);
  assign iss_valid  = |ready;
  assign iss_fire   = iss_valid && iss_ready;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_op     = ent_q[sel_idx].op;
  assign iss_vj     = ent_q[sel_idx].vj;
  assign iss_vk     = ent_q[sel_idx].vk;
  assign iss_imm    = ent_q[sel_idx].imm;
  assign iss_pc     = ent_q[sel_idx].pc;
  assign iss_dest   = ent_q[sel_idx].dest;

  // Dispatch-time bypass; iterating downward lets the lowest CDB port win.
  always_comb begin
    disp_ent.op   = disp_op;
    disp_ent.vj   = disp_vj;
    disp_ent.vk   = disp_vk;
    disp_ent.imm  = disp_imm;
    disp_ent.pc   = disp_pc;
    disp_ent.qj   = disp_qj;
    disp_ent.qk   = disp_qk;
    disp_ent.dest = disp_dest;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && disp_qj != '0 && cdb_tag[k*TAG_W +: TAG_W] == disp_qj) begin
        disp_ent.vj = cdb_data[k*XLEN +: XLEN];
        disp_ent.qj = '0;
      end
      if (cdb_valid[k] && disp_qk != '0 && cdb_tag[k*TAG_W +: TAG_W] == disp_qk) begin
        disp_ent.vk = cdb_data[k*XLEN +: XLEN];
        disp_ent.qk = '0;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i]   = ent_q[i];
      older_d[i] = older_q[i];
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (busy_q[i] && cdb_valid[k] && ent_q[i].qj != '0 &&
            cdb_tag[k*TAG_W +: TAG_W] == ent_q[i].qj) begin
          ent_d[i].vj = cdb_data[k*XLEN +: XLEN];
          ent_d[i].qj = '0;
        end
        if (busy_q[i] && cdb_valid[k] && ent_q[i].qk != '0 &&
            cdb_tag[k*TAG_W +: TAG_W] == ent_q[i].qk) begin
          ent_d[i].vk = cdb_data[k*XLEN +: XLEN];
          ent_d[i].qk = '0;
        end
      end
    end
    if (iss_fire) busy_d[sel_idx] = 1'b0;
    if (disp_fire) begin
      busy_d[alloc_idx]  = 1'b1;
      ent_d[alloc_idx]   = disp_ent;
      older_d[alloc_idx] = busy_q & ~(iss_fire ? sel_oh : '0);
      for (int j = 0; j < RS_SIZE; j++) older_d[j][alloc_idx] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush_pipeline) begin
      busy_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i].qj <= '0;
        ent_q[i].qk <= '0;
        older_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_exu_rs.sv
// Directed and randomized bench for ysyx_exu_rs against an age-ordered queue model.
module tb_ysyx_exu_rs;

  localparam int XLEN = 32, RS = 4, TW = 5, NC = 2, OW = 5;

  logic            clock = 1'b0;
  logic            reset, flush_pipeline, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [OW-1:0]   disp_op, iss_op;
  logic [XLEN-1:0] disp_vj, disp_vk, disp_imm, disp_pc;
  logic [TW-1:0]   disp_qj, disp_qk, disp_dest, iss_dest;
  logic [NC-1:0]   cdb_valid;
  logic [NC*TW-1:0]   cdb_tag;
  logic [NC*XLEN-1:0] cdb_data;
  logic [XLEN-1:0] iss_vj, iss_vk, iss_imm, iss_pc;
  logic [2:0]      occupancy;

  ysyx_exu_rs dut (
    .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_dest(disp_dest), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_dest(iss_dest), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OW-1:0]   op;
    logic [XLEN-1:0] vj, vk, imm, pc;
    logic [TW-1:0]   qj, qk, dest;
  } ment_t;

  ment_t mq[$];  // index 0 is the oldest entry
  bit    model_valid = 0;
  int    n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].qj == 0 && mq[i].qk == 0) return i;
    return -1;
  endfunction

  function automatic logic [TW-1:0] ctag(int k);
    return cdb_tag[k*TW +: TW];
  endfunction

  function automatic logic [XLEN-1:0] cdat(int k);
    return cdb_data[k*XLEN +: XLEN];
  endfunction

  task automatic model_check();
    int s;
    if (!model_valid) return;
    s = oldest_ready();
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("disp_ready", 64'(disp_ready), 64'(mq.size() < RS));
    check("iss_valid", 64'(iss_valid), 64'(s >= 0));
    if (s >= 0) begin
      check("iss_dest", 64'(iss_dest), 64'(mq[s].dest));
      check("iss_op", 64'(iss_op), 64'(mq[s].op));
      check("iss_vj", 64'(iss_vj), 64'(mq[s].vj));
      check("iss_vk", 64'(iss_vk), 64'(mq[s].vk));
      check("iss_imm", 64'(iss_imm), 64'(mq[s].imm));
      check("iss_pc", 64'(iss_pc), 64'(mq[s].pc));
    end
  endtask

  // Wake one operand: first matching valid port with a nonzero tag supplies the value.
  task automatic wake(inout logic [TW-1:0] q, inout logic [XLEN-1:0] v);
    if (q == 0) return;
    for (int k = 0; k < NC; k++) begin
      if (cdb_valid[k] && ctag(k) == q) begin
        v = cdat(k);
        q = '0;
        return;
      end
    end
  endtask

  task automatic model_update();
    int    s;
    bit    fi, fd;
    ment_t e;
    if (!reset) begin
      mq.delete();
      model_valid = 1;
      return;
    end
    if (!model_valid) return;
    if (flush_pipeline) begin
      mq.delete();
      return;
    end
    s  = oldest_ready();
    fi = (s >= 0) && iss_ready;
    fd = disp_valid && (mq.size() < RS);
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      wake(e.qj, e.vj);
      wake(e.qk, e.vk);
      mq[i] = e;
    end
    if (fi) mq.delete(s);
    if (fd) begin
      e.op = disp_op; e.vj = disp_vj; e.vk = disp_vk; e.imm = disp_imm; e.pc = disp_pc;
      e.qj = disp_qj; e.qk = disp_qk; e.dest = disp_dest;
      wake(e.qj, e.vj);
      wake(e.qk, e.vk);
      mq.push_back(e);
    end
  endtask

  // Compare, advance the model with the current inputs, then cross the clock edge.
  task automatic tick();
    model_check();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic set_disp(input logic v, input logic [TW-1:0] dest, input logic [TW-1:0] qj,
                          input logic [TW-1:0] qk);
    disp_valid = v; disp_dest = dest; disp_qj = qj; disp_qk = qk;
    disp_op = OW'($urandom); disp_vj = $urandom; disp_vk = $urandom;
    disp_imm = $urandom; disp_pc = $urandom;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [TW-1:0] t0, input logic [XLEN-1:0] d0,
                         input logic [TW-1:0] t1, input logic [XLEN-1:0] d1);
    cdb_valid = v; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
  endtask

  initial begin
    reset = 0; flush_pipeline = 0; iss_ready = 0;
    set_cdb(2'b00, 0, 0, 0, 0);
    set_disp(1, 3, 0, 0);
    @(negedge clock);
    // Reset held for two edges with a dispatch pending
    tick(); tick();
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    reset = 1;
    tick();
    set_disp(0, 0, 0, 0);
    check("first_iss_valid", 64'(iss_valid), 64'd1);
    check("first_iss_dest", 64'(iss_dest), 64'd3);
    iss_ready = 1; tick(); iss_ready = 0;

    // Age order
    set_disp(1, 1, 5, 0); tick();
    set_disp(1, 2, 0, 0); tick();
    set_disp(1, 4, 6, 0); tick();
    set_disp(0, 0, 0, 0);
    check("age_first", 64'(iss_dest), 64'd2);
    set_cdb(2'b01, 6, 32'h55, 0, 0); tick(); set_cdb(2'b00, 0, 0, 0, 0);
    check("age_hold", 64'(iss_dest), 64'd2);
    iss_ready = 1; tick();
    check("age_second", 64'(iss_dest), 64'd4);
    check("age_second_vj", 64'(iss_vj), 64'h55);
    tick();
    check("age_stale_valid", 64'(iss_valid), 64'd0);
    check("age_stale_occ", 64'(occupancy), 64'd1);
    set_cdb(2'b01, 5, 32'h77, 0, 0); tick(); set_cdb(2'b00, 0, 0, 0, 0);
    check("age_last", 64'(iss_dest), 64'd1);
    tick(); iss_ready = 0;

    // Dispatch bypass on CDB port 1
    set_disp(1, 8, 0, 7); set_cdb(2'b10, 0, 0, 7, 32'hDEAD); tick();
    set_disp(0, 0, 0, 0); set_cdb(2'b00, 0, 0, 0, 0);
    check("bypass_valid", 64'(iss_valid), 64'd1);
    check("bypass_vk", 64'(iss_vk), 64'hDEAD);
    iss_ready = 1; tick(); iss_ready = 0;

    // Both CDBs wake one entry in the same cycle
    set_disp(1, 12, 3, 9); tick(); set_disp(0, 0, 0, 0);
    check("dual_wait", 64'(iss_valid), 64'd0);
    set_cdb(2'b11, 3, 32'h11, 9, 32'h22); tick(); set_cdb(2'b00, 0, 0, 0, 0);
    check("dual_vj", 64'(iss_vj), 64'h11);
    check("dual_vk", 64'(iss_vk), 64'h22);
    iss_ready = 1; tick(); iss_ready = 0;

    // Full boundary
    for (int i = 0; i < 4; i++) begin
      set_disp(1, TW'(10 + i), 0, 0); tick();
    end
    check("full_ready", 64'(disp_ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'd4);
    iss_ready = 1; set_disp(1, 20, 0, 0); tick(); set_disp(0, 0, 0, 0);
    check("full_ready_after", 64'(disp_ready), 64'd1);
    check("full_occ_after", 64'(occupancy), 64'd3);
    repeat (4) tick();
    iss_ready = 0;

    // Flush discards dispatch and wakeup in the same cycle
    for (int i = 0; i < 3; i++) begin
      set_disp(1, TW'(21 + i), 8, 0); tick();
    end
    flush_pipeline = 1; set_disp(1, 30, 0, 0); set_cdb(2'b01, 8, 32'h99, 0, 0); tick();
    flush_pipeline = 0; set_disp(0, 0, 0, 0); set_cdb(2'b00, 0, 0, 0, 0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_iss_valid", 64'(iss_valid), 64'd0);
    tick();
    check("flush_dropped", 64'(occupancy), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_disp($urandom_range(0, 1), TW'($urandom_range(1, 31)),
               ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 7)),
               ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 7)));
      set_cdb(2'($urandom), TW'($urandom_range(0, 7)), $urandom,
              TW'($urandom_range(0, 7)), $urandom);
      iss_ready      = ($urandom_range(0, 3) != 0);
      flush_pipeline = ($urandom_range(0, 60) == 0);
      reset          = ($urandom_range(0, 200) != 0);
      tick();
    end
    reset = 1; flush_pipeline = 0;
    set_disp(0, 0, 0, 0); set_cdb(2'b00, 0, 0, 0, 0);
    tick();
    model_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_exu_rs.md
Name: ysyx_exu_rs

Overview:
- Parametrised, generalised reservation station for the out-of-order backend. Sits between IDU dispatch and one functional unit (ALU, MUL or LSU address-gen); one instance per unit.
- Wakes operands from NUM_CDB parallel result buses.
- Issues the oldest fully-ready entry each cycle using an age matrix, unlike lowest-index selection.
- Supports pipeline flush and per-entry occupancy reporting.

Parameters:
- XLEN, 32, operand/result width.
- RS_SIZE, 4, entry count; must be ≥2 and a power of two.
- ROB_SIZE, 16, ROB depth. TAG_W = $clog2(ROB_SIZE)+1. Tag 0 means "value present".
- NUM_CDB, 2, number of wakeup/result broadcast ports.
- OP_W, 5, alu_op width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- flush_pipeline  in  1  discard all entries
- disp_valid  in  1  IDU has an instruction
- disp_ready  out  1  RS can accept
- disp_op  in  OP_W  operation code
- disp_vj, disp_vk  in  XLEN  operand values
- disp_qj, disp_qk  in  TAG_W  producer tags (0 = ready)
- disp_dest  in  TAG_W  ROB tag of this instruction
- disp_imm, disp_pc  in  XLEN  immediate, pc
- cdb_valid  in  NUM_CDB  broadcast valid per port
- cdb_tag  in  NUM_CDB*TAG_W  packed tags, port k at [k*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*XLEN  packed results
- iss_valid  out  1  an entry is issuing
- iss_ready  in  1  FU accepts
- iss_op  out  OP_W  issued operation
- iss_vj, iss_vk, iss_imm, iss_pc  out  XLEN  issued operands
- iss_dest  out  TAG_W  issued ROB tag
- occupancy  out  $clog2(RS_SIZE)+1  busy entry count

Behaviour:
- Reset (reset==0 at posedge): busy, qj, qk and the age matrix are cleared. Reset has priority over flush, dispatch, issue and wakeup.
- Values after reset: iss_valid=0, occupancy=0, disp_ready=1. All outputs are combinational from state.
- Flush (reset==1, flush_pipeline==1): same clearing as reset. Dispatch, issue and wakeup in that cycle are discarded.
- disp_ready = !(&busy). A free slot is never reused in the cycle it issues, so full stays full for that cycle.
- Dispatch fires on disp_valid && disp_ready. It writes the lowest-index free entry at the edge; busy=1.
- Dispatch bypass: if any cdb port k is valid and cdb_tag[k]==disp_qj with disp_qj!=0, the entry stores vj=cdb_data[k] and qj=0. Same rule for qk. Lowest k wins on duplicate tags.
- Wakeup: every busy entry with qj!=0 matching a valid CDB tag captures data and clears qj at the edge. Same rule for qk. Tag 0 on the CDB is ignored.
- Ready[i] = busy[i] && qj==0 && qk==0. An entry woken at edge t is ready in cycle t+1; there is no same-cycle CDB-to-issue path.
- Age matrix: older[i][j]=1 means j is older than i. On allocating entry i: older[i][j]=busy[j] && !(issuing j this edge), and older[j][i]=0 for all j.
- Select: issue the ready entry i such that no ready j has older[i][j]=1. At most one candidate exists.
- iss_valid = any ready entry. The iss_* fields come from the selected entry.
- Issue handshake: on iss_valid && iss_ready, the selected entry's busy clears at the edge. Its column is ignored thereafter because busy=0 masks it.
- While iss_ready==0, the selection may change if an older entry becomes ready. The FU must sample only on handshake.
- Latency: dispatch with both tags 0 at edge t → iss_valid in cycle t+1.
- Simultaneous dispatch and issue: both occur and occupancy is unchanged.
- occupancy = popcount(busy).
- Stale entries: a qj/qk tag that is never broadcast leaves the entry waiting indefinitely. Only flush removes it; no timeout.

Test Plan:
- Reset: hold reset=0 for 2 cycles with disp_valid=1 → occupancy=0, iss_valid=0, disp_ready=1. After release, one dispatch (qj=qk=0, dest=3) → iss_valid=1 next cycle with iss_dest=3.
- Age order: dispatch A(dest=1,qj=5), B(dest=2,qj=0), C(dest=4,qj=6), iss_ready=0.
  - iss_dest=2.
  - CDB tag 6 data 0x55 → iss_dest still 2.
  - With iss_ready=1: B issues, then C (iss_vj=0x55) issues before A.
- Bypass: disp_qk=7 while cdb_valid[1]=1, cdb_tag=7, data=0xDEAD → entry issues next cycle with iss_vk=0xDEAD.
- Dual-CDB wakeup: entry qj=3, qk=9; port0 tag 3 data 0x11 and port1 tag 9 data 0x22 in the same cycle → next cycle iss_vj=0x11, iss_vk=0x22.
- Full boundary: fill 4 entries → disp_ready=0. Issue one with disp_valid=1 in that cycle → no write that edge; disp_ready=1 the next cycle, occupancy=3.
- Flush: 3 busy entries, flush_pipeline=1 alongside a dispatch and a CDB broadcast → occupancy=0, iss_valid=0, and the new instruction is dropped.
